// File: rtl/adder_share_pkg.sv
// Shared types, constants and the round-robin pick function for the
// time-shared adder arbiter.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W  = 16;
  localparam int MAX_REQ = 8;

  // Scan downward so the last hit is the closest valid index above 'last';
  // 'last' itself has the lowest priority. With no valid bit, 'last' is returned.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int last,
                                 input int num_req);
    int idx;
    rr_pick = last;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= num_req) begin
        idx = (last + i) % num_req;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/FA_sixteen.sv
// 16-bit ripple-carry adder; the carry out of the top bit is not produced
// because no user of this adder needs it.
module FA_sixteen (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S
);

  logic [15:0] carry;

  assign carry[0] = Cin;

  genvar i;
  generate
    for (i = 0; i < 15; i++) begin : g_carry
      assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end
  endgenerate

  assign S = A ^ B ^ carry;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one FA_sixteen adder between
// NUM_REQ requesters, returning each sum with the requester ID.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic [DATA_W-1:0]  rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  fa_sum;
  logic [MAX_REQ-1:0] valid_ext;
  logic [ID_W-1:0]    grant;

  assign valid_ext = MAX_REQ'(req_valid);
  assign grant     = ID_W'(rr_pick(valid_ext, int'(last_grant_q), NUM_REQ));

  FA_sixteen u_fa (
    .A   (op_a_q),
    .B   (op_b_q),
    .Cin (1'b0),
    .S   (fa_sum)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          op_a_d           = req_a[grant*DATA_W +: DATA_W];
          op_b_d           = req_b[grant*DATA_W +: DATA_W];
          rsp_id_d         = grant;
          last_grant_d     = grant;
          state_d          = CALC;
        end
      end
      CALC: begin
        rsp_sum_d = fa_sum;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so the grant must be masked explicitly.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with NUM_REQ = 4:
// single ops, wraparound, round-robin rotation, backpressure, reset, capture.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_sum;
  logic [1:0]  rsp_id;
  logic        busy;

  int tests_run = 0;
  int fail_count = 0;

  adder_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] rr_sum [4];
  int          rr_order [5];

  initial begin
    rr_sum[0] = 16'h1112;
    rr_sum[1] = 16'h2232;
    rr_sum[2] = 16'h3433;
    rr_sum[3] = 16'h1000;
    rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;

    rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rsp_sum", 32'(rsp_sum), 32'h0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);

    // Single operation from requester 0
    rst = 1'b0; req_valid = 4'b0001;
    applyStimulus(0, 16'h0003, 16'h0004);
    #1;
    checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    checkOutput("t1_calc_busy", 32'(busy), 32'h1);
    checkOutput("t1_calc_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t1_calc_req_ready", 32'(req_ready), 32'h0);
    tick();
    #1;
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_sum", 32'(rsp_sum), 32'h0007);
    checkOutput("t1_rsp_id", 32'(rsp_id), 32'h0);
    rsp_ready = 1'b1;
    tick();
    #1;
    checkOutput("t1_done_busy", 32'(busy), 32'h0);
    checkOutput("t1_done_rsp_valid", 32'(rsp_valid), 32'h0);

    // Wraparound
    req_valid = 4'b0001;
    applyStimulus(0, 16'hFFFF, 16'h0002);
    #1;
    checkOutput("t2_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t2_rsp_sum", 32'(rsp_sum), 32'h0001);
    tick();

    // Round-robin rotation from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 16'h1111, 16'h0001);
    applyStimulus(1, 16'h2222, 16'h0010);
    applyStimulus(2, 16'h3333, 16'h0100);
    applyStimulus(3, 16'hF000, 16'h2000);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(1) << rr_order[k]);
      tick();
      tick();
      #1;
      checkOutput($sformatf("t3_valid%0d", k), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("t3_id%0d", k), 32'(rsp_id), 32'(rr_order[k]));
      checkOutput($sformatf("t3_sum%0d", k), 32'(rsp_sum), 32'(rr_sum[rr_order[k]]));
      tick();
    end

    // Backpressure: last grant was 0, so requester 1 wins next
    req_valid = 4'b0010; rsp_ready = 1'b0;
    applyStimulus(1, 16'h0005, 16'h000A);
    #1;
    checkOutput("t4_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0110;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("t4_hold_valid%0d", k), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("t4_hold_sum%0d", k), 32'(rsp_sum), 32'h000F);
      checkOutput($sformatf("t4_hold_id%0d", k), 32'(rsp_id), 32'h1);
      checkOutput($sformatf("t4_hold_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    checkOutput("t4_release_busy", 32'(busy), 32'h0);
    checkOutput("t4_next_grant", 32'(req_ready), 32'h4);

    // Reset while requester 2 is in CALC
    tick();
    #1;
    checkOutput("t5_calc_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    #1;
    checkOutput("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
    checkOutput("t5_rst_req_ready", 32'(req_ready), 32'h0);
    rst = 1'b0; req_valid = 4'b0101;
    #1;
    checkOutput("t5_first_grant", 32'(req_ready), 32'h1);

    // Operand capture: change inputs after grant
    req_valid = 4'b0010;
    applyStimulus(1, 16'h1234, 16'h1111);
    #1;
    checkOutput("t6_req_ready", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(1, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0000;
    tick();
    #1;
    checkOutput("t6_rsp_sum", 32'(rsp_sum), 32'h2345);
    checkOutput("t6_rsp_id", 32'(rsp_id), 32'h1);
    tick();
    #1;
    checkOutput("t6_done_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
